pixel_unpacker: RTL
===================

Name: pixel_unpacker

Overview:
- AXI4-Stream sink that reverses the pixel packer: consumes 32-bit words carrying tightly packed 24-bit RGB pixels (4 pixels per 3 words) and emits one pixel per handshake.
- Regenerates start-of-frame and end-of-line markers, tracks the pixel column, and flags framing errors.
- Sits between the video DMA/stream interconnect and pixel-domain consumers (checker, scaler, test monitor).

Parameters:
- X_SIZE, 640, pixels per line; must be a multiple of 4.
- X_BITS, 10, width of the column counter.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  reset, synchronous, active-low.
- in_stream_tdata  in  32  packed pixel bytes.
- in_stream_tkeep  in  4  must be 4'hF.
- in_stream_tlast  in  1  last word of a line.
- in_stream_tuser  in  1  first word of a frame.
- in_stream_tvalid  in  1  word valid.
- in_stream_tready  out  1  word accepted when tvalid and tready are both high.
- r, g, b  out  8 each  pixel components.
- valid  out  1  pixel valid.
- ready  in  1  downstream accepts the pixel when valid and ready are both high.
- sof  out  1  qualifies the pixel as first of frame.
- eol  out  1  qualifies the pixel as last of line.
- x  out  X_BITS  column of the current output pixel.
- err  out  1  sticky framing error.
- err_clear  in  1  clears err.

Behaviour:
- Byte map within a 12-byte group, little-endian; pixel byte order is b, g, r from low to high:
  - W0 = {p1.b, p0.r, p0.g, p0.b}
  - W1 = {p2.g, p2.b, p1.r, p1.g}
  - W2 = {p3.r, p3.g, p3.b, p2.r}
- Phase FSM:
  - PH0: accept W0, emit p0, store byte3 as carry.
  - PH1: accept W1, emit p1, store bytes 3:2.
  - PH2: accept W2, emit p2, store bytes 3:1 as p3.
  - PH3: no input accepted; emit stored p3.
  - Transitions are PH0→PH1→PH2→PH3→PH0. Each transition occurs on the output-register load for that phase.
- Output register:
  - One pixel deep. It loads when (!valid || ready).
  - in_stream_tready = (phase != PH3) && (!valid || ready) && aresetn.
  - PH3 advances when (!valid || ready).
  - Latency: pixel appears on outputs the cycle after the word handshake. Full throughput is 4 pixels per 4 cycles with ready held high.
- sof:
  - Set on p0 when the W0 handshake has tuser=1.
  - tuser=1 in PH1/PH2 (resync): treat that word as W0, emit p0 with sof=1, discard the carry, set err, go to PH1.
- eol:
  - Set on p3 when W2 had tlast=1.
  - tlast in PH0/PH1 (short line): the pixel emitted from that word carries eol=1, set err, next phase is PH0, carry discarded.
- x:
  - Resets to 0 on any sof pixel and after any eol pixel; otherwise increments per output load.
  - Reaching x==X_SIZE-1 without eol, or eol with x!=X_SIZE-1, sets err. x wraps to 0 after X_SIZE-1 regardless.
- err:
  - Set on any tkeep!=4'hF handshake or any condition above.
  - err_clear has priority over a simultaneous set.
- Held data: r/g/b/sof/eol/x must stay stable while valid && !ready.
- Reset (aresetn=0 at a clock edge, including mid-group or with valid held):
  - phase=PH0, valid=0, sof=0, eol=0, r=g=b=0, x=0, err=0, in_stream_tready=0, carry cleared.
  - Words presented during reset are not accepted.

Test Plan:
- Aligned group: W0=0x44332211 with tuser=1, W1=0x88776655, W2=0xCCBBAA99, ready=1.
  - Required pixels {r,g,b}: p0={33,22,11} with sof=1, p1={66,55,44}, p2={99,88,77}, p3={CC,BB,AA}.
  - x=0..3; tready low exactly in the PH3 cycle; err=0.
- Full line: 480 words with tlast on word 480.
  - 640 pixels; eol only on the pixel with x=639; x returns to 0; err=0.
- Backpressure: ready toggled 1010… over the aligned group.
  - Same 4 pixels in order, outputs stable while stalled, no word lost.
  - tready never high when valid && !ready.
- Short line: tlast on W1 of the group above.
  - p1={66,55,44} with eol=1; err=1; next word decoded as W0.
- Resync: tuser=1 on a word presented in PH2 with value 0x00ABCDEF.
  - Pixel {AB,CD,EF} with sof=1 and x=0; err=1.
  - Then err_clear pulse → err=0.
- Reset mid-group: aresetn low for 1 cycle after W1 is accepted.
  - valid=0 and x=0 next cycle; the next W0 decodes correctly as p0.

Source files
------------

// File: rtl/pixel_unpacker.sv
// AXI4-Stream sink that unpacks 24-bit RGB pixels from 32-bit words (4 pixels per 3 words),
// regenerating sof/eol, tracking the column and flagging framing errors.
module pixel_unpacker #(
    parameter int X_SIZE = 640,
    parameter int X_BITS = 10
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [31:0]       in_stream_tdata,
    input  logic [3:0]        in_stream_tkeep,
    input  logic              in_stream_tlast,
    input  logic              in_stream_tuser,
    input  logic              in_stream_tvalid,
    output logic              in_stream_tready,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              valid,
    input  logic              ready,
    output logic              sof,
    output logic              eol,
    output logic [X_BITS-1:0] x,
    output logic              err,
    input  logic              err_clear
);

    typedef enum logic [1:0] {PH0 = 2'd0, PH1 = 2'd1, PH2 = 2'd2, PH3 = 2'd3} phase_e;

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(X_SIZE - 1);

    phase_e              phase_q, phase_d, eff_phase_s;
    logic [23:0]         carry_q, carry_d;
    logic                last_q, last_d;
    logic                valid_q, valid_d;
    logic [7:0]          r_q, r_d, g_q, g_d, b_q, b_d;
    logic                sof_q, sof_d, eol_q, eol_d;
    logic [X_BITS-1:0]   x_q, x_d, col_q, col_d, x_new_s;
    logic                err_q, err_d;
    logic                load_s, hs_s, resync_s, load_px_s, set_s;
    logic [7:0]          pr_s, pg_s, pb_s;
    logic                psof_s, peol_s;

    assign load_s           = !valid_q || ready;
    assign in_stream_tready = (phase_q != PH3) && load_s && aresetn;
    assign hs_s             = in_stream_tvalid && in_stream_tready;
    assign resync_s         = hs_s && in_stream_tuser && (phase_q == PH1 || phase_q == PH2);

    // Next-state decode: pixel extraction, phase sequencing, column tracking and error detection.
    always_comb begin
        phase_d   = phase_q;
        carry_d   = carry_q;
        last_d    = last_q;
        valid_d   = valid_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        sof_d     = sof_q;
        eol_d     = eol_q;
        x_d       = x_q;
        col_d     = col_q;
        load_px_s = 1'b0;
        set_s     = 1'b0;
        pr_s      = 8'h00;
        pg_s      = 8'h00;
        pb_s      = 8'h00;
        psof_s    = 1'b0;
        peol_s    = 1'b0;
        x_new_s   = '0;
        // A resync word restarts the group, so it decodes exactly like W0.
        eff_phase_s = resync_s ? PH0 : phase_q;

        if (load_s) begin
            if (hs_s) begin
                load_px_s = 1'b1;
                case (eff_phase_s)
                    PH0: begin
                        pb_s    = in_stream_tdata[7:0];
                        pg_s    = in_stream_tdata[15:8];
                        pr_s    = in_stream_tdata[23:16];
                        psof_s  = in_stream_tuser;
                        carry_d = {16'h0000, in_stream_tdata[31:24]};
                        phase_d = PH1;
                    end
                    PH1: begin
                        pb_s    = carry_q[7:0];
                        pg_s    = in_stream_tdata[7:0];
                        pr_s    = in_stream_tdata[15:8];
                        carry_d = {8'h00, in_stream_tdata[31:16]};
                        phase_d = PH2;
                    end
                    PH2: begin
                        pb_s    = carry_q[7:0];
                        pg_s    = carry_q[15:8];
                        pr_s    = in_stream_tdata[7:0];
                        carry_d = in_stream_tdata[31:8];
                        last_d  = in_stream_tlast;
                        phase_d = PH3;
                    end
                    default: begin
                        phase_d = PH0;
                    end
                endcase
                if (in_stream_tlast && eff_phase_s != PH2) begin
                    peol_s  = 1'b1;
                    phase_d = PH0;
                    carry_d = 24'h000000;
                    set_s   = 1'b1;
                end else begin
                    peol_s = 1'b0;
                end
                if (resync_s || in_stream_tkeep != 4'hF) begin
                    set_s = 1'b1;
                end else begin
                    set_s = set_s;
                end
            end else if (phase_q == PH3) begin
                load_px_s = 1'b1;
                pb_s      = carry_q[7:0];
                pg_s      = carry_q[15:8];
                pr_s      = carry_q[23:16];
                peol_s    = last_q;
                last_d    = 1'b0;
                carry_d   = 24'h000000;
                phase_d   = PH0;
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end

        if (load_px_s) begin
            x_new_s = psof_s ? '0 : col_q;
            valid_d = 1'b1;
            r_d     = pr_s;
            g_d     = pg_s;
            b_d     = pb_s;
            sof_d   = psof_s;
            eol_d   = peol_s;
            x_d     = x_new_s;
            col_d   = (peol_s || x_new_s == X_LAST) ? '0 : x_new_s + X_BITS'(1);
            if ((x_new_s == X_LAST) != peol_s) begin
                set_s = 1'b1;
            end else begin
                set_s = set_s;
            end
        end else begin
            x_d = x_q;
        end

        err_d = err_clear ? 1'b0 : (err_q | set_s);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            phase_q <= PH0;
            carry_q <= 24'h000000;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            r_q     <= 8'h00;
            g_q     <= 8'h00;
            b_q     <= 8'h00;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            x_q     <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            carry_q <= carry_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            x_q     <= x_d;
            col_q   <= col_d;
            err_q   <= err_d;
        end
    end

    assign valid = valid_q;
    assign r     = r_q;
    assign g     = g_q;
    assign b     = b_q;
    assign sof   = sof_q;
    assign eol   = eol_q;
    assign x     = x_q;
    assign err   = err_q;

endmodule
